jkff_drive: RTL and testbench
=============================

# jkff_drive

Excitation driver for a bank of gate-level JK flip-flops (`jkff`). It accepts a target register value over a valid/ready handshake and derives per-bit J/K excitation from the bank's current `q`. It drives `j`/`k` for exactly one clock, then checks that `q` reached the target, retrying on mismatch. It sits in front of a `jkff` bank and is the write/control end of the J/K interface those flip-flops receive.

## Interface
- `WIDTH`, 4: number of JK flip-flops driven.
- `MAX_RETRY`, 2: extra DRIVE attempts after a failed CHECK (0..7).
- `clk` in 1: single clock; all state updates on rising edge.
- `cl` in 1: reset, synchronous, active-high.
- `tgt_valid` in 1: target word present.
- `tgt_ready` out 1: driver can accept a target.
- `tgt` in WIDTH: desired next `q` of the bank.
- `q` in WIDTH: feedback from the `jkff` bank outputs.
- `j` out WIDTH: J inputs to the bank.
- `k` out WIDTH: K inputs to the bank.
- `done` out 1: one-cycle pulse when a transaction finishes.
- `err` out 1: valid with `done`; 1 means the target was not reached.
- `err_cnt` out 8: saturating count of failed transactions.

## Operation
- FSM states: IDLE, DRIVE, CHECK.
- Reset (`cl`=1 at an edge):
  - State goes to IDLE.
  - `j`=`k`=0, `done`=`err`=0, `err_cnt`=0, retry counter=0.
  - `tgt_ready`=0 while `cl` is high, 1 on the first cycle after release.
  - A transaction in progress is dropped without a `done` pulse.
- IDLE:
  - `tgt_ready`=1 and `j`=`k`=0 (hold).
  - On `tgt_valid`&&`tgt_ready`, latch `tgt` into `tgt_r`, clear the retry counter, go to DRIVE.
- DRIVE (exactly one cycle):
  - `tgt_ready`=0.
  - Per bit, computed from `q` sampled in this cycle against `tgt_r`:
    - 0→0: J=0, K=0.
    - 0→1: J=1, K=0.
    - 1→0: J=0, K=1.
    - 1→1: J=0, K=0.
  - Next state is CHECK.
- CHECK (one cycle):
  - `j`=`k`=0.
  - If `q`==`tgt_r`: pulse `done`=1, `err`=0, go to IDLE.
  - Else if retry counter < `MAX_RETRY`: increment it, go to DRIVE.
  - Else: pulse `done`=1, `err`=1, increment `err_cnt` (saturates at 255), go to IDLE.
- `tgt` is ignored outside IDLE; `tgt_valid` may stay high.
- `q` change in bits already at target is not treated specially; only the CHECK compare matters.

## Timing
- `j`, `k`, `done`, `err`, `tgt_ready` are registered outputs.
- Handshake accepted at edge E0 → DRIVE cycle (E0..E1) with `j`/`k` valid → bank samples at E1 → CHECK cycle (E1..E2) → `done` high in cycle E2..E3 with IDLE and `tgt_ready`=1.
- Clean transaction: 3 cycles from accept to `done`. Back-to-back throughput: one target per 3 cycles.
- Each retry adds 2 cycles. Worst case is 3+2·`MAX_RETRY` cycles.
- `done` and `tgt_ready` are both high in the same cycle, so a new target may be accepted in the `done` cycle.
- A `cl` pulse during DRIVE forces `j`=`k`=0 in the next cycle.

## Configuration
- `JKFF_DRIVE_TOGGLE_EN`:
  - Defined: bits that must change are driven with J=1, K=1 (toggle). Bits that must hold get J=0, K=0.
  - Undefined: set/reset encoding as listed under Operation.
- Timing, retry and `err_cnt` behaviour are identical in both builds.

## Test plan
- Reset: `cl`=1 for 2 cycles → `j`=`k`=0, `done`=0, `err_cnt`=0, `tgt_ready`=0; after release `tgt_ready`=1.
- Clean write: bank `q`=4'b0000, `tgt`=4'b1010 accepted.
  - Next cycle `j`=4'b1010, `k`=4'b0000; with `JKFF_DRIVE_TOGGLE_EN`, `j`=`k`=4'b1010.
  - Two cycles later `done`=1, `err`=0.
- Mixed transitions: `q`=4'b1100, `tgt`=4'b1010 → `j`=4'b0010, `k`=4'b0100; with the toggle macro, `j`=`k`=4'b0110. `done`=1, `err`=0.
- Stuck bit: bank bit 0 forced to 0, `tgt`=4'b0001, `MAX_RETRY`=2.
  - DRIVE asserted 3 times, `done`=1 and `err`=1 at cycle 7 after accept, `err_cnt`=1.
- Back-to-back: `tgt_valid` held high with 0101 then 1111 → second accept lands in the first transaction's `done` cycle; `done` pulses 3 cycles apart.
- Reset mid-operation: `cl` asserted during DRIVE → no `done` pulse, `j`=`k`=0 next cycle, `err_cnt` cleared.

Source files
------------

// File: rtl/jkff_drive.sv
// J/K excitation driver for a jkff bank: drive one cycle, check, retry.
// Define JKFF_DRIVE_TOGGLE_EN to excite changing bits with J=K=1.
module jkff_drive #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             cl,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_t;

  localparam logic [2:0] MAXR = 3'(MAX_RETRY);

  state_t           state, state_nx;
  logic [WIDTH-1:0] tgt_r, tgt_nx;
  logic [WIDTH-1:0] want;
  logic [WIDTH-1:0] j_nx, k_nx;
  logic [2:0]       rty, rty_nx;
  logic             drive;
  logic             done_nx, err_nx, rdy_nx;
  logic [7:0]       cnt_nx;

  always_comb begin
    state_nx = state;
    tgt_nx   = tgt_r;
    rty_nx   = rty;
    want     = tgt_r;
    drive    = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    cnt_nx   = err_cnt;
    j_nx     = '0;
    k_nx     = '0;
    unique case (state)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          tgt_nx   = tgt;
          want     = tgt;
          rty_nx   = '0;
          drive    = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: state_nx = CHECK;
      CHECK: begin
        if (q == tgt_r) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (rty < MAXR) begin
          rty_nx   = rty + 3'd1;
          drive    = 1'b1;
          state_nx = DRIVE;
        end else begin
          done_nx  = 1'b1;
          err_nx   = 1'b1;
          if (err_cnt != 8'hFF)
            cnt_nx = err_cnt + 8'd1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // j/k are registered, so they are derived at the edge entering DRIVE
    if (drive) begin
`ifdef JKFF_DRIVE_TOGGLE_EN
      j_nx = want ^ q;
      k_nx = want ^ q;
`else
      j_nx = want & ~q;
      k_nx = ~want & q;
`endif
    end
    rdy_nx = (state_nx == IDLE);
  end

  always_ff @(posedge clk) begin
    if (cl) begin
      state     <= IDLE;
      tgt_r     <= '0;
      rty       <= '0;
      j         <= '0;
      k         <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      tgt_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      tgt_r     <= tgt_nx;
      rty       <= rty_nx;
      j         <= j_nx;
      k         <= k_nx;
      done      <= done_nx;
      err       <= err_nx;
      err_cnt   <= cnt_nx;
      tgt_ready <= rdy_nx;
    end
  end

endmodule

// File: tb/tb_jkff_drive.sv
// Scoreboard bench for jkff_drive with a behavioural jkff bank
// that can pin selected bits to a stuck value.
module tb_jkff_drive;

  localparam int W    = 4;
  localparam int MAXR = 2;

  logic         clk = 1'b0;
  logic         cl;
  logic         tgt_valid;
  logic         tgt_ready;
  logic [W-1:0] tgt;
  logic [W-1:0] q;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         done;
  logic         err;
  logic [7:0]   err_cnt;

  logic [W-1:0] bank_r = '0;
  logic [W-1:0] sm;
  logic [W-1:0] sv;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  jkff_drive #(.WIDTH(W), .MAX_RETRY(MAXR)) dut (
    .clk(clk),
    .cl(cl),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt(tgt),
    .q(q),
    .j(j),
    .k(k),
    .done(done),
    .err(err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // JK characteristic: hold, reset, set, toggle; stuck bits override
  assign q = (bank_r & ~sm) | (sv & sm);
  always @(posedge clk)
    bank_r <= (j & ~k) | (~j & ~k & bank_r) | (j & k & ~bank_r);

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, a, e, cyc);
    end
  endtask

  function automatic logic [W-1:0] ej(input logic [W-1:0] t,
                                      input logic [W-1:0] c);
`ifdef JKFF_DRIVE_TOGGLE_EN
    return t ^ c;
`else
    return t & ~c;
`endif
  endfunction

  function automatic logic [W-1:0] ek(input logic [W-1:0] t,
                                      input logic [W-1:0] c);
`ifdef JKFF_DRIVE_TOGGLE_EN
    return t ^ c;
`else
    return ~t & c;
`endif
  endfunction

  // Tracker: an accept happens at the posedge following this negedge
  initial begin
    int   fails;
    exp_t e;
    fails = 0;
    forever begin
      @(negedge clk);
      if (cl === 1'b1) begin
        sb.delete();
        fails = 0;
      end else if (tgt_valid === 1'b1 && tgt_ready === 1'b1) begin
        e.err = (((tgt ^ sv) & sm) != '0);
        if (e.err && fails < 255)
          fails++;
        e.cnt = 8'(fails);
        e.cyc = cyc + 3 + (e.err ? 2 * MAXR : 0);
        sb.push_back(e);
      end
    end
  end

  // Monitor: pops and compares whenever done is presented
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_missing: none by cyc %0d want cyc %0d",
               cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected: got done=1 want 0 (cyc %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cyc", cyc, e.cyc);
        chk("done_err", {31'b0, err}, {31'b0, e.err});
        chk("done_err_cnt", {24'b0, err_cnt}, {24'b0, e.cnt});
      end
    end
  end

  task automatic send(input logic [W-1:0] t, input bit keep,
                      output int acc, output logic [W-1:0] q_at);
    int n;
    tgt       = t;
    tgt_valid = 1'b1;
    n         = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tgt_ready !== 1'b1 && n < 50);
    if (tgt_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got ready=%b want 1", tgt_ready);
    end
    acc  = cyc;
    q_at = q;
    @(posedge clk);
    #1;
    if (!keep)
      tgt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || tgt_ready !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got pending=%0d want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int           acc, acc2, drv;
    logic [W-1:0] qa, tr;
    cl        = 1'b1;
    tgt_valid = 1'b0;
    tgt       = '0;
    sm        = '0;
    sv        = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_j", {28'b0, j}, 0);
    chk("rst_k", {28'b0, k}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 0);
    chk("rst_ready", {31'b0, tgt_ready}, 0);
    @(posedge clk);
    #1 cl = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rel_ready", {31'b0, tgt_ready}, 1);
    @(posedge clk);
    #1;

    send(4'b1010, 1'b0, acc, qa);
    @(negedge clk);
    chk("clean_j", {28'b0, j}, {28'b0, ej(4'b1010, 4'b0000)});
    chk("clean_k", {28'b0, k}, {28'b0, ek(4'b1010, 4'b0000)});
    wait_idle();

    send(4'b1100, 1'b0, acc, qa);
    wait_idle();
    send(4'b1010, 1'b0, acc, qa);
    @(negedge clk);
    chk("mixed_j", {28'b0, j}, {28'b0, ej(4'b1010, 4'b1100)});
    chk("mixed_k", {28'b0, k}, {28'b0, ek(4'b1010, 4'b1100)});
    wait_idle();

    sm = 4'b0001;
    sv = 4'b0000;
    send(4'b0001, 1'b0, acc, qa);
    drv = 0;
    repeat (8) begin
      @(negedge clk);
      if ((j | k) != '0)
        drv++;
    end
    chk("stuck_drives", drv, MAXR + 1);
    wait_idle();
    chk("stuck_err_cnt", {24'b0, err_cnt}, 1);
    sm = '0;

    send(4'b0101, 1'b1, acc, qa);
    send(4'b1111, 1'b0, acc2, qa);
    chk("b2b_spacing", acc2 - acc, 3);
    wait_idle();

    tr = ~q;
    send(tr, 1'b0, acc, qa);
    cl = 1'b1;
    @(posedge clk);
    #1 cl = 1'b0;
    @(negedge clk);
    chk("midrst_j", {28'b0, j}, 0);
    chk("midrst_k", {28'b0, k}, 0);
    chk("midrst_err_cnt", {24'b0, err_cnt}, 0);
    repeat (8) @(negedge clk);
    wait_idle();

    for (int it = 0; it < 30; it++) begin
      wait_idle();
      sm = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : '0;
      sv = 4'($urandom);
      repeat (1 + $urandom_range(0, 3))
        send(4'($urandom), 1'($urandom_range(0, 1)), acc, qa);
      tgt_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();

    sm = 4'b0001;
    sv = 4'b0000;
    for (int i = 0; i < 260; i++)
      send(4'b0001, 1'b1, acc, qa);
    tgt_valid = 1'b0;
    wait_idle();
    chk("sat_err_cnt", {24'b0, err_cnt}, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
